// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART receiver: parity modes and FSM states.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus falling-edge detect
// on the synchronised value. All flops reset to the idle-high line level.
module uart_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic rx_o,
    output logic fall_o
);

    logic meta_q;
    logic rxS_q;
    logic rxPrev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q   <= 1'b1;
            rxS_q    <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            meta_q   <= line_i;
            rxS_q    <= meta_q;
            rxPrev_q <= rxS_q;
        end
    end

    assign rx_o   = rxS_q;
    assign fall_o = rxPrev_q & ~rxS_q;

endmodule

// File: rtl/uart_receiver_param.sv
// Parameterised UART receiver: mid-bit sampling, optional parity, 1-2 stop bits,
// and a held output word with valid/ready handshake and overrun reporting.
module uart_receiver_param
    import uart_pkg::*;
#(
    parameter int CYCLES_PER_SYMBOL = 1085,
    parameter int DATA_BITS         = 8,
    parameter int PARITY            = 0,
    parameter int STOP_BITS         = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signal_in,
    input  logic                 data_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(CYCLES_PER_SYMBOL);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES_PER_SYMBOL - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'((CYCLES_PER_SYMBOL - 1) / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          PAR_ODD  = (PARITY == PARITY_ODD);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    logic                 rxS;
    logic                 rxFall;
    rx_state_e            state_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bitIdx_q;
    logic                 stopIdx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parErr_q;
    logic                 stopErr_q;
    logic [DATA_BITS-1:0] dataOut_q;
    logic                 dataValid_q;
    logic                 parityErr_q;
    logic                 frameErr_q;
    logic                 overrun_q;

    logic sample;
    logic parErr_d;
    logic frameErr_d;

    uart_sync uSync (
        .clk_i  (clk),
        .rst_i  (rst),
        .line_i (signal_in),
        .rx_o   (rxS),
        .fall_o (rxFall)
    );

    assign sample     = (cnt_q == CNT_MID);
    assign parErr_d   = ((^shift_q) ^ rxS) != PAR_ODD;
    assign frameErr_d = stopErr_q | ~rxS;

    // Bits arrive LSB first, so shifting in from the top leaves the first bit at bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bitIdx_q    <= '0;
            stopIdx_q   <= 1'b0;
            shift_q     <= '0;
            parErr_q    <= 1'b0;
            stopErr_q   <= 1'b0;
            dataOut_q   <= '0;
            dataValid_q <= 1'b0;
            parityErr_q <= 1'b0;
            frameErr_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (dataValid_q && data_ready) begin
                dataValid_q <= 1'b0;
            end
            if (state_q == IDLE) begin
                cnt_q <= '0;
                if (rxFall) begin
                    state_q <= START;
                end
            end else begin
                cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
                if (sample) begin
                    case (state_q)
                        START: begin
                            if (rxS) begin
                                state_q <= IDLE;
                            end else begin
                                state_q  <= DATA;
                                bitIdx_q <= '0;
                            end
                        end
                        DATA: begin
                            shift_q <= {rxS, shift_q[DATA_BITS-1:1]};
                            if (bitIdx_q == BIT_LAST) begin
                                state_q   <= (PARITY != PARITY_NONE) ? PAR : STOP;
                                stopIdx_q <= 1'b0;
                                stopErr_q <= 1'b0;
                                parErr_q  <= 1'b0;
                            end else begin
                                bitIdx_q <= bitIdx_q + 1'b1;
                            end
                        end
                        PAR: begin
                            parErr_q <= parErr_d;
                            state_q  <= STOP;
                        end
                        STOP: begin
                            if (stopIdx_q == STOP_LAST) begin
                                // Leave mid-stop-bit so a back-to-back start edge is not missed.
                                state_q <= IDLE;
                                if (!dataValid_q || data_ready) begin
                                    dataOut_q   <= shift_q;
                                    parityErr_q <= parErr_q;
                                    frameErr_q  <= frameErr_d;
                                    dataValid_q <= 1'b1;
                                end else begin
                                    overrun_q <= 1'b1;
                                end
                            end else begin
                                stopIdx_q <= 1'b1;
                                stopErr_q <= frameErr_d;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign data_out   = dataOut_q;
    assign data_valid = dataValid_q;
    assign parity_err = parityErr_q;
    assign frame_err  = frameErr_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_receiver_param.sv
// Self-checking bench: an even-parity 8-cycle receiver and a no-parity two-stop 4-cycle receiver.
module tb_uart_receiver_param;

    localparam int CPS_A = 8;
    localparam int CPS_B = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } word_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sigA, readyA, validA, perrA, ferrA, ovrA;
    logic [7:0] dataA;
    logic       sigB, readyB, validB, perrB, ferrB, ovrB;
    logic [7:0] dataB;

    int checks   = 0;
    int failures = 0;

    word_t      capA[$];
    logic [7:0] capB[$];
    int         ovrCount   = 0;
    int         flagCountB = 0;
    word_t      monWord;

    uart_receiver_param #(
        .CYCLES_PER_SYMBOL(CPS_A), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
    ) dutA (
        .clk(clk), .rst(rst), .signal_in(sigA), .data_ready(readyA),
        .data_out(dataA), .data_valid(validA), .parity_err(perrA),
        .frame_err(ferrA), .overrun(ovrA)
    );

    uart_receiver_param #(
        .CYCLES_PER_SYMBOL(CPS_B), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)
    ) dutB (
        .clk(clk), .rst(rst), .signal_in(sigB), .data_ready(readyB),
        .data_out(dataB), .data_valid(validB), .parity_err(perrB),
        .frame_err(ferrB), .overrun(ovrB)
    );

    always @(negedge clk) begin
        if (!rst && validA && readyA) begin
            monWord.data = dataA;
            monWord.perr = perrA;
            monWord.ferr = ferrA;
            capA.push_back(monWord);
        end
        if (ovrA) ovrCount++;
        if (!rst && validB && readyB) begin
            capB.push_back(dataB);
            if (perrB || ferrB) flagCountB++;
        end
        if (ovrB) flagCountB++;
    end

    // Reference: even parity means data ones plus parity bit must total an even count.
    function automatic word_t modelA(input logic [7:0] d, input logic pbit, input logic stopv);
        word_t m;
        m.data = d;
        m.perr = ((($countones(d) + int'(pbit)) % 2) == 1);
        m.ferr = (stopv == 1'b0);
        return m;
    endfunction

    task automatic holdA(input logic v);
        sigA = v;
        repeat (CPS_A) @(posedge clk);
        #1;
    endtask

    task automatic sendA(input logic [7:0] d, input logic pbit, input logic stopv, input int gapBits);
        holdA(1'b0);
        for (int i = 0; i < 8; i++) holdA(d[i]);
        holdA(pbit);
        holdA(stopv);
        for (int i = 0; i < gapBits; i++) holdA(1'b1);
        sigA = 1'b1;
    endtask

    task automatic holdB(input logic v);
        sigB = v;
        repeat (CPS_B) @(posedge clk);
        #1;
    endtask

    task automatic sendB(input logic [7:0] d, input int gapBits);
        holdB(1'b0);
        for (int i = 0; i < 8; i++) holdB(d[i]);
        holdB(1'b1);
        holdB(1'b1);
        for (int i = 0; i < gapBits; i++) holdB(1'b1);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; sigA = 1'b1; sigB = 1'b1; readyA = 1'b1; readyB = 1'b1;
        idleCycles(4);
        checks++; if (validA !== 1'b0) begin failures++; $display("[TB] FAIL reset_validA: got %b expected 0", validA); end
        checks++; if (dataA !== 8'h00) begin failures++; $display("[TB] FAIL reset_dataA: got %h expected 00", dataA); end
        checks++; if ({perrA, ferrA, ovrA} !== 3'b000) begin failures++; $display("[TB] FAIL reset_flagsA: got %b expected 000", {perrA, ferrA, ovrA}); end
        checks++; if ({validB, dataB} !== 9'h000) begin failures++; $display("[TB] FAIL reset_B: got %h expected 000", {validB, dataB}); end
        rst = 1'b0;
        idleCycles(6);
    endtask

    task automatic test_basic;
        capA.delete();
        sendA(8'hA5, 1'b0, 1'b1, 2);
        checks++; if (capA.size() !== 1) begin failures++; $display("[TB] FAIL basic_count: got %0d words expected 1", capA.size()); end
        if (capA.size() >= 1) begin
            checks++;
            if (capA[0] !== modelA(8'hA5, 1'b0, 1'b1)) begin
                failures++; $display("[TB] FAIL basic_word: got %h/%b/%b expected a5/0/0", capA[0].data, capA[0].perr, capA[0].ferr);
            end
        end
        checks++; if (validA !== 1'b0) begin failures++; $display("[TB] FAIL basic_pulse: valid still %b expected 0", validA); end
    endtask

    task automatic test_errors;
        capA.delete();
        sendA(8'h3C, 1'b1, 1'b1, 2);
        sendA(8'h00, 1'b0, 1'b0, 2);
        checks++; if (capA.size() !== 2) begin failures++; $display("[TB] FAIL err_count: got %0d words expected 2", capA.size()); end
        if (capA.size() >= 2) begin
            checks++;
            if (capA[0] !== word_t'({8'h3C, 1'b1, 1'b0})) begin
                failures++; $display("[TB] FAIL err_parity: got %h/%b/%b expected 3c/1/0", capA[0].data, capA[0].perr, capA[0].ferr);
            end
            checks++;
            if (capA[1] !== word_t'({8'h00, 1'b0, 1'b1})) begin
                failures++; $display("[TB] FAIL err_frame: got %h/%b/%b expected 00/0/1", capA[1].data, capA[1].perr, capA[1].ferr);
            end
        end
    endtask

    task automatic test_random;
        word_t      expQ[$];
        logic [7:0] d;
        logic       pbit, stopv;
        int         gap;
        capA.delete();
        for (int i = 0; i < 24; i++) begin
            d     = 8'($urandom_range(0, 255));
            pbit  = ($urandom_range(0, 3) != 0) ? ($countones(d) % 2 == 1) : ($countones(d) % 2 == 0);
            stopv = ($urandom_range(0, 5) != 0);
            gap   = stopv ? $urandom_range(0, 2) : $urandom_range(1, 2);
            expQ.push_back(modelA(d, pbit, stopv));
            sendA(d, pbit, stopv, gap);
        end
        idleCycles(3 * CPS_A);
        checks++; if (capA.size() !== expQ.size()) begin failures++; $display("[TB] FAIL rand_count: got %0d words expected %0d", capA.size(), expQ.size()); end
        for (int i = 0; i < expQ.size() && i < capA.size(); i++) begin
            checks++;
            if (capA[i] !== expQ[i]) begin
                failures++; $display("[TB] FAIL rand_word%0d: got %h/%b/%b expected %h/%b/%b", i,
                    capA[i].data, capA[i].perr, capA[i].ferr, expQ[i].data, expQ[i].perr, expQ[i].ferr);
            end
        end
    endtask

    task automatic test_glitch;
        capA.delete();
        sigA = 1'b0;
        idleCycles(2);
        sigA = 1'b1;
        idleCycles(3 * CPS_A);
        checks++; if (capA.size() !== 0 || validA !== 1'b0) begin failures++; $display("[TB] FAIL glitch_valid: got %0d words valid=%b expected none", capA.size(), validA); end
        sendA(8'h5A, 1'b0, 1'b1, 2);
        checks++;
        if (capA.size() !== 1 || capA[0] !== word_t'({8'h5A, 1'b0, 1'b0})) begin
            failures++; $display("[TB] FAIL glitch_recover: got %0d words expected one 5a/0/0", capA.size());
        end
    endtask

    task automatic test_back_to_back;
        capA.delete();
        ovrCount = 0;
        readyA   = 1'b0;
        sendA(8'h11, 1'b0, 1'b1, 0);
        sendA(8'h22, 1'b0, 1'b1, 2);
        checks++; if (validA !== 1'b1 || dataA !== 8'h11) begin failures++; $display("[TB] FAIL b2b_hold: got valid=%b data=%h expected 1/11", validA, dataA); end
        checks++; if (ovrCount !== 1) begin failures++; $display("[TB] FAIL b2b_overrun: got %0d cycles expected 1", ovrCount); end
        readyA = 1'b1;
        idleCycles(5);
        checks++;
        if (capA.size() !== 1 || capA[0].data !== 8'h11) begin
            failures++; $display("[TB] FAIL b2b_accept: got %0d words expected one 11", capA.size());
        end
        checks++; if (validA !== 1'b0) begin failures++; $display("[TB] FAIL b2b_clear: got valid=%b expected 0", validA); end
    endtask

    task automatic test_reset_midframe;
        capA.delete();
        holdA(1'b0);
        holdA(1'b1);
        holdA(1'b0);
        holdA(1'b1);
        rst  = 1'b1;
        sigA = 1'b1;
        idleCycles(3);
        rst = 1'b0;
        idleCycles(2 * CPS_A);
        sendA(8'h0F, 1'b0, 1'b1, 2);
        checks++;
        if (capA.size() !== 1 || capA[0] !== word_t'({8'h0F, 1'b0, 1'b0})) begin
            failures++; $display("[TB] FAIL rst_mid: got %0d words expected one 0f/0/0", capA.size());
        end
    endtask

    task automatic test_reset_clears;
        readyA = 1'b0;
        sendA(8'h3C, 1'b1, 1'b0, 2);
        checks++; if ({validA, dataA, perrA, ferrA} !== {1'b1, 8'h3C, 1'b1, 1'b1}) begin failures++; $display("[TB] FAIL held_word: got %b/%h/%b/%b expected 1/3c/1/1", validA, dataA, perrA, ferrA); end
        rst = 1'b1;
        idleCycles(2);
        rst = 1'b0;
        checks++; if ({validA, dataA, perrA, ferrA} !== 11'h000) begin failures++; $display("[TB] FAIL rst_clear: got %b/%h/%b/%b expected 0/00/0/0", validA, dataA, perrA, ferrA); end
        readyA = 1'b1;
        idleCycles(4);
    endtask

    task automatic test_sweep;
        capB.delete();
        flagCountB = 0;
        for (int d = 0; d < 256; d++) sendB(8'(d), 1);
        idleCycles(4 * CPS_B);
        checks++; if (capB.size() !== 256) begin failures++; $display("[TB] FAIL sweep_count: got %0d words expected 256", capB.size()); end
        for (int i = 0; i < 256 && i < capB.size(); i++) begin
            checks++;
            if (capB[i] !== 8'(i)) begin failures++; $display("[TB] FAIL sweep_byte%0d: got %h expected %h", i, capB[i], 8'(i)); end
        end
        checks++; if (flagCountB !== 0) begin failures++; $display("[TB] FAIL sweep_flags: got %0d flagged expected 0", flagCountB); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_random();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        test_reset_clears();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
